// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for the elastic MEM/WB stage: upstream payload in, downstream payload out.
// valid/ready: a beat moves on a clock edge where valid && ready; valid never waits on ready.
interface pipe_skid_stage_if #(
  parameter int W = 131
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic MEM/WB pipeline stage: main + skid buffer with registered upstream ready,
// synchronous flush and a saturating stall counter for performance debug.
module pipe_skid_stage #(
  parameter int W           = 131,
  parameter int ZERO_BUBBLE = 1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               stall_clr_i,
  pipe_skid_stage_if.slave   bus,
  output logic [1:0]         occupancy_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [1:0]         state_o
);

  // State bits are {main_valid, skid_valid}; {0,1} cannot occur.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_TWO   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic main_valid;
  logic skid_valid;
  logic acc_fire;
  logic rel_fire;
  logic stall;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];

  // Upstream ready comes only from registered state, flush and reset, never from out_ready.
  assign bus.in_ready  = !skid_valid && !flush_i && !rst;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_q;

  assign acc_fire = bus.in_valid && bus.in_ready;
  assign rel_fire = main_valid && bus.out_ready;
  assign stall    = main_valid && !bus.out_ready;

  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt_o = stall_cnt_q;
  assign state_o     = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      if (ZERO_BUBBLE != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc_fire) begin
            state_d = S_ONE;
            main_d  = bus.in_data;
          end
        end
        S_ONE: begin
          if (acc_fire && rel_fire) begin
            main_d = bus.in_data;
          end else if (acc_fire) begin
            state_d = S_TWO;
            skid_d  = bus.in_data;
          end else if (rel_fire) begin
            state_d = S_EMPTY;
            if (ZERO_BUBBLE != 0) begin
              main_d = '0;
            end
          end
        end
        S_TWO: begin
          if (rel_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
            if (ZERO_BUBBLE != 0) begin
              skid_d = '0;
            end
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle stall; the count sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
    !(skid_valid && !main_valid));

  a_hold_under_stall: assert property (@(posedge clk) disable iff (rst)
    (main_valid && !bus.out_ready && !flush_i) |=> $stable(bus.out_data));

endmodule
